// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: framed serial-in/parallel-out controller.
// After frame_start it collects WIDTH strobed bits MSB-first into a shift
// register, then moves the finished word into a holding register that is
// drained by a valid/ready handshake. Words that arrive while the holding
// register is still full are dropped and flagged with a sticky overrun bit.
// A frame that stalls too long between bits is aborted with a timeout pulse.
module sipo_frame_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             timeout
);

  // Idle counter only needs to hold values up to TIMEOUT-1.
  localparam int IDLE_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IDLE_MAX_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam bit TO_EN        = (TIMEOUT > 0);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_MAX_INT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shreg_reg, shreg_next;
  logic [WIDTH-1:0]   p_out_reg, p_out_next;
  logic               p_valid_reg, p_valid_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic               overrun_reg, overrun_next;
  logic               timeout_reg, timeout_next;
  logic               busy_reg;
  logic [WIDTH-1:0]   word_shifted;

  // Shift register contents after accepting s_in this cycle.
  assign word_shifted = {shreg_reg[WIDTH-2:0], s_in};

  // Next-state and datapath decode; every target gets a hold/default first.
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    p_out_next    = p_out_reg;
    // A handshake drains the holding register unless a new word reloads it.
    p_valid_next  = p_valid_reg & ~out_ready;
    overrun_next  = overrun_reg & ~overrun_clr;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next    = SHIFT;
          shreg_next    = '0;
          bit_cnt_next  = '0;
          idle_cnt_next = '0;
        end
      end

      SHIFT: begin
        if (frame_start) begin
          // Restart: any bit strobed in this cycle is ignored.
          shreg_next    = '0;
          bit_cnt_next  = '0;
          idle_cnt_next = '0;
        end else if (s_valid) begin
          idle_cnt_next = '0;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            shreg_next   = '0;
            if (!p_valid_reg || out_ready) begin
              p_out_next   = word_shifted;
              p_valid_next = 1'b1;
            end else begin
              // Holding register full and not draining: drop, set wins over clear.
              overrun_next = 1'b1;
            end
          end else begin
            shreg_next   = word_shifted;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end else begin
          if (TO_EN && (idle_cnt_reg == IDLE_MAX)) begin
            state_next    = IDLE;
            bit_cnt_next  = '0;
            shreg_next    = '0;
            idle_cnt_next = '0;
            timeout_next  = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      p_out_reg    <= '0;
      p_valid_reg  <= 1'b0;
      bit_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      p_out_reg    <= p_out_next;
      p_valid_reg  <= p_valid_next;
      bit_cnt_reg  <= bit_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      overrun_reg  <= overrun_next;
      timeout_reg  <= timeout_next;
      busy_reg     <= (state_next == SHIFT);
    end
  end

  assign p_out   = p_out_reg;
  assign p_valid = p_valid_reg;
  assign busy    = busy_reg;
  assign bit_cnt = bit_cnt_reg;
  assign overrun = overrun_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed testbench for sipo_frame_ctrl (WIDTH=4, TIMEOUT=16).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_sipo_frame_ctrl;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_in = 1'b0;
  logic             s_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             out_ready = 1'b0;
  logic             overrun_clr = 1'b0;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             timeout;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .p_out(p_out), .p_valid(p_valid), .busy(busy), .bit_cnt(bit_cnt),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; land 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // Send WIDTH bits MSB first on consecutive cycles; optional clear on final bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic clr_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      s_valid = 1'b1;
      s_in    = w[i];
      overrun_clr = (i == 0) ? clr_last : 1'b0;
      cyc();
    end
    s_valid = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_in    = b;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({p_out, p_valid, busy, bit_cnt, overrun, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got p_out=%h p_valid=%b busy=%b bit_cnt=%0d overrun=%b timeout=%b, want all 0",
               p_out, p_valid, busy, bit_cnt, overrun, timeout);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    logic [3:0] bits;
    bits = 4'b1011;
    out_ready = 1'b1;
    start_frame();
    n_checks++;
    if (busy !== 1'b1 || bit_cnt !== 0) begin
      n_fail++;
      $display("FAIL basic_start: busy=%b bit_cnt=%0d, want busy=1 bit_cnt=0", busy, bit_cnt);
    end
    for (int i = 3; i >= 1; i--) begin
      s_valid = 1'b1;
      s_in = bits[i];
      cyc();
      n_checks++;
      if (bit_cnt !== CNT_W'(4 - i) || busy !== 1'b1 || p_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_bitcnt: bit_cnt=%0d busy=%b p_valid=%b, want %0d 1 0", bit_cnt, busy, p_valid, 4 - i);
      end
    end
    s_in = bits[0];
    cyc();
    s_valid = 1'b0;
    n_checks++;
    if (p_out !== 4'b1011 || p_valid !== 1'b1 || busy !== 1'b0 || bit_cnt !== 0) begin
      n_fail++;
      $display("FAIL basic_word: p_out=%b p_valid=%b busy=%b bit_cnt=%0d, want 1011 1 0 0", p_out, p_valid, busy, bit_cnt);
    end
    cyc();
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: p_valid=%b, want 0", p_valid);
    end
    $display("test_basic_frame done: p_out=%b", p_out);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    start_frame();
    send_word(4'b1100, 1'b0);
    n_checks++;
    if (p_out !== 4'b1100 || p_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: p_out=%b p_valid=%b overrun=%b, want 1100 1 0", p_out, p_valid, overrun);
    end
    start_frame();
    send_word(4'b0101, 1'b0);
    n_checks++;
    if (p_out !== 4'b1100 || p_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drop: p_out=%b p_valid=%b overrun=%b, want 1100 1 1", p_out, p_valid, overrun);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (p_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drain: p_valid=%b overrun=%b, want 0 1", p_valid, overrun);
    end
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: overrun=%b, want 0", overrun);
    end
    start_frame();
    send_word(4'h3, 1'b0);
    start_frame();
    send_word(4'h6, 1'b1);
    n_checks++;
    if (overrun !== 1'b1 || p_out !== 4'h3) begin
      n_fail++;
      $display("FAIL ovr_set_wins: overrun=%b p_out=%h, want 1 3", overrun, p_out);
    end
    overrun_clr = 1'b1;
    out_ready = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_cleanup: overrun=%b p_valid=%b, want 0 0", overrun, p_valid);
    end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    w = 4'h5;
    out_ready = 1'b0;
    start_frame();
    send_word(4'hA, 1'b0);
    start_frame();
    for (int i = 3; i >= 1; i--) send_bit(w[i]);
    n_checks++;
    if (p_valid !== 1'b1 || p_out !== 4'hA) begin
      n_fail++;
      $display("FAIL b2b_hold: p_valid=%b p_out=%h, want 1 a", p_valid, p_out);
    end
    out_ready = 1'b1;
    send_bit(w[0]);
    n_checks++;
    if (p_valid !== 1'b1 || p_out !== 4'h5 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reload: p_valid=%b p_out=%h overrun=%b, want 1 5 0", p_valid, p_out, overrun);
    end
    cyc();
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: p_valid=%b, want 0", p_valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_restart();
    out_ready = 1'b1;
    start_frame();
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (bit_cnt !== 2) begin
      n_fail++;
      $display("FAIL restart_partial: bit_cnt=%0d, want 2", bit_cnt);
    end
    frame_start = 1'b1;
    s_valid = 1'b1;
    s_in = 1'b1;
    cyc();
    frame_start = 1'b0;
    s_valid = 1'b0;
    n_checks++;
    if (bit_cnt !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: bit_cnt=%0d busy=%b, want 0 1", bit_cnt, busy);
    end
    send_word(4'b0011, 1'b0);
    n_checks++;
    if (p_out !== 4'b0011 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_word: p_out=%b p_valid=%b, want 0011 1", p_out, p_valid);
    end
    cyc();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    n_checks++;
    if (bit_cnt !== 0 || p_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: bit_cnt=%0d p_valid=%b busy=%b, want 0 0 0", bit_cnt, p_valid, busy);
    end
    $display("test_restart done");
  endtask

  task automatic test_timeout();
    int early;
    out_ready = 1'b0;
    start_frame();
    send_word(4'h9, 1'b0);
    start_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    early = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cyc();
      if (timeout !== 1'b0 || busy !== 1'b1) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL timeout_early: %0d cycles with timeout/busy wrong in first 15, want 0", early);
    end
    cyc();
    n_checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || bit_cnt !== 0 || p_valid !== 1'b1 || p_out !== 4'h9) begin
      n_fail++;
      $display("FAIL timeout_abort: timeout=%b busy=%b bit_cnt=%0d p_valid=%b p_out=%h, want 1 0 0 1 9",
               timeout, busy, bit_cnt, p_valid, p_out);
    end
    cyc();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: timeout=%b, want 0", timeout);
    end
    out_ready = 1'b1;
    cyc();
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    n_checks++;
    if (busy !== 1'b1 || timeout !== 1'b0 || bit_cnt !== 2) begin
      n_fail++;
      $display("FAIL gap15_alive: busy=%b timeout=%b bit_cnt=%0d, want 1 0 2", busy, timeout, bit_cnt);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    n_checks++;
    if (p_out !== 4'b0110 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gap15_word: p_out=%b p_valid=%b, want 0110 1", p_out, p_valid);
    end
    cyc();
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    start_frame();
    send_word(4'hF, 1'b0);
    start_frame();
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({p_out, p_valid, busy, bit_cnt, overrun, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: p_out=%h p_valid=%b busy=%b bit_cnt=%0d overrun=%b timeout=%b, want all 0",
               p_out, p_valid, busy, bit_cnt, overrun, timeout);
    end
    for (int i = 0; i < WIDTH; i++) send_bit(1'b1);
    cyc();
    n_checks++;
    if (bit_cnt !== 0 || p_valid !== 1'b0 || busy !== 1'b0 || p_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_no_capture: bit_cnt=%0d p_valid=%b busy=%b p_out=%h, want 0 0 0 0", bit_cnt, p_valid, busy, p_out);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_frame();
    test_overrun();
    test_back_to_back();
    test_restart();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
